// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, funct codes, ALU operation codes,
// squash FSM encoding and the ID/EX pipeline register layout.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    SqRun    = 1'b0,
    SqSquash = 1'b1
  } squash_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } idex_t;

  function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/register_file.sv
// Two-read/one-write register file with r0 hardwired to zero and same-cycle
// write-through bypass on both read ports.
module register_file #(
  parameter int unsigned NREG = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] rf_q [NREG];
  logic [31:0] rf_d [NREG];
  logic        wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0) && (32'(waddr_i) < NREG);

  always_comb begin
    rf_d = rf_q;
    if (wr_en) begin
      rf_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Bypass lets an instruction in decode see the value written back this cycle.
  always_comb begin
    rdata1_o = '0;
    if (raddr1_i == 5'd0) begin
      rdata1_o = '0;
    end else if (wr_en && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end else if (32'(raddr1_i) < NREG) begin
      rdata1_o = rf_q[raddr1_i];
    end
  end

  always_comb begin
    rdata2_o = '0;
    if (raddr2_i == 5'd0) begin
      rdata2_o = '0;
    end else if (wr_en && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end else if (32'(raddr2_i) < NREG) begin
      rdata2_o = rf_q[raddr2_i];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: register file, control decode, sign extension and the
// ID/EX pipeline register with two-bubble squash after a taken branch.
module decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrDe,
  input  logic [31:0] PCDe,
  input  logic [31:0] PCplus4De,
  input  logic        FlushEx,
  input  logic        RegWriteWb,
  input  logic [4:0]  RdWb,
  input  logic [31:0] ResultWb,
  output logic        RegWriteEx,
  output logic        MemWriteEx,
  output logic        ResultSrcEx,
  output logic        BranchEx,
  output logic        ALUSrcEx,
  output logic        RegDstEx,
  output logic [2:0]  ALUControlEx,
  output logic [31:0] RD1Ex,
  output logic [31:0] RD2Ex,
  output logic [31:0] ImmExtEx,
  output logic [4:0]  RsEx,
  output logic [4:0]  RtEx,
  output logic [4:0]  RdEx,
  output logic [31:0] PCEx,
  output logic [31:0] PCplus4Ex
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        unused_shamt;

  assign opcode       = InstrDe[31:26];
  assign rs           = InstrDe[25:21];
  assign rt           = InstrDe[20:16];
  assign rd           = InstrDe[15:11];
  assign funct        = InstrDe[5:0];
  assign unused_shamt = ^InstrDe[10:6];

  register_file #(
    .NREG (NREG)
  ) u_register_file (
    .clk_i    (clk),
    .rst_ni   (rst),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rd1),
    .rdata2_o (rd2),
    .we_i     (RegWriteWb),
    .waddr_i  (RdWb),
    .wdata_i  (ResultWb)
  );

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_RTYPE: begin
        // Unknown funct leaves every control low so it behaves as a NOP.
        unique case (funct)
          FN_ADD:  ctrl.alu_control = ALU_ADD;
          FN_SUB:  ctrl.alu_control = ALU_SUB;
          FN_AND:  ctrl.alu_control = ALU_AND;
          FN_OR:   ctrl.alu_control = ALU_OR;
          FN_SLT:  ctrl.alu_control = ALU_SLT;
          default: ctrl.alu_control = ALU_AND;
        endcase
        if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.result_src  = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      default: ctrl = '0;
    endcase
  end

  squash_e squash_q, squash_d;
  idex_t   idex_q, idex_d;
  idex_t   bubble;
  logic    kill;

  // Squash lasts two edges: the instruction in decode now, then the one fetch
  // loads on the redirect edge. A new flush restarts the window.
  always_comb begin
    squash_d = SqRun;
    kill     = 1'b0;
    unique case (squash_q)
      SqRun: begin
        if (FlushEx) begin
          squash_d = SqSquash;
          kill     = 1'b1;
        end
      end
      SqSquash: begin
        kill     = 1'b1;
        squash_d = FlushEx ? SqSquash : SqRun;
      end
      default: squash_d = SqRun;
    endcase
  end

  always_comb begin
    bubble          = '0;
    bubble.pc       = RST_PC;
    bubble.pc_plus4 = RST_PC;

    idex_d          = bubble;
    if (!kill) begin
      idex_d.ctrl     = ctrl;
      idex_d.rd1      = rd1;
      idex_d.rd2      = rd2;
      idex_d.imm_ext  = sign_extend16(InstrDe[15:0]);
      idex_d.rs       = rs;
      idex_d.rt       = rt;
      idex_d.rd       = rd;
      idex_d.pc       = PCDe;
      idex_d.pc_plus4 = PCplus4De;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      squash_q         <= SqRun;
      idex_q           <= '0;
      idex_q.pc        <= RST_PC;
      idex_q.pc_plus4  <= RST_PC;
    end else begin
      squash_q <= squash_d;
      idex_q   <= idex_d;
    end
  end

  assign RegWriteEx   = idex_q.ctrl.reg_write;
  assign MemWriteEx   = idex_q.ctrl.mem_write;
  assign ResultSrcEx  = idex_q.ctrl.result_src;
  assign BranchEx     = idex_q.ctrl.branch;
  assign ALUSrcEx     = idex_q.ctrl.alu_src;
  assign RegDstEx     = idex_q.ctrl.reg_dst;
  assign ALUControlEx = idex_q.ctrl.alu_control;
  assign RD1Ex        = idex_q.rd1;
  assign RD2Ex        = idex_q.rd2;
  assign ImmExtEx     = idex_q.imm_ext;
  assign RsEx         = idex_q.rs;
  assign RtEx         = idex_q.rt;
  assign RdEx         = idex_q.rd;
  assign PCEx         = idex_q.pc;
  assign PCplus4Ex    = idex_q.pc_plus4;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- MIPS pipeline decode stage. Consumes the fetch→decode interface (InstrDe, PCDe, PCplus4De) and produces the ID/EX pipeline register.
- Holds the register file, main/ALU control decode and sign extension.
- Squashes wrong-path instructions after a taken branch, using the same PCsrcEx signal that drives fetch (FlushEx input).

Parameters:
- NREG, 32, number of architectural registers (index width 5).
- RST_PC, 32'h00000000, PCEx/PCplus4Ex value on reset and on bubble.

Ports:
- clk in 1 system clock, rising edge.
- rst in 1 asynchronous active-low reset.
- InstrDe in 32 instruction from fetch register.
- PCDe in 32 PC of InstrDe.
- PCplus4De in 32 PC+4 of InstrDe.
- FlushEx in 1 taken-branch redirect (tied to PCsrcEx).
- RegWriteWb in 1 writeback enable.
- RdWb in 5 writeback register index.
- ResultWb in 32 writeback data.
- RegWriteEx out 1 register write control.
- MemWriteEx out 1 memory write control.
- ResultSrcEx out 1 writeback select, 1 = memory.
- BranchEx out 1 instruction is beq.
- ALUSrcEx out 1 1 = immediate operand.
- RegDstEx out 1 1 = rd, 0 = rt.
- ALUControlEx out 3 ALU operation code.
- RD1Ex out 32 rs data.
- RD2Ex out 32 rt data.
- ImmExtEx out 32 sign-extended imm16.
- RsEx out 5 rs index.
- RtEx out 5 rt index.
- RdEx out 5 rd index.
- PCEx out 32 PC of instruction.
- PCplus4Ex out 32 PC+4 of instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - all Ex outputs 0, with PCEx and PCplus4Ex = RST_PC;
  - all registers = 0;
  - squash_pend = 0.
- Decode, by opcode [31:26]:
  - 0x00 R-type: RegWrite=1, RegDst=1, ALUSrc=0. Funct 0x20 ADD (010), 0x22 SUB (110), 0x24 AND (000), 0x25 OR (001), 0x2A SLT (111). Any other funct → all controls 0.
  - 0x23 lw: RegWrite=1, ALUSrc=1, ResultSrc=1, ADD.
  - 0x2B sw: MemWrite=1, ALUSrc=1, ADD.
  - 0x04 beq: Branch=1, SUB.
  - 0x08 addi: RegWrite=1, ALUSrc=1, ADD.
  - Any other opcode: all controls 0 (NOP). InstrDe = 0 is therefore a bubble.
- ImmExt = {{16{Instr[15]}}, Instr[15:0]}.
- Rs/Rt/Rd = Instr[25:21] / [20:16] / [15:11].
- Register file:
  - Write on posedge when RegWriteWb=1 and RdWb≠0.
  - Register 0 reads 0 always.
  - Reads are combinational with write-through bypass: if RegWriteWb=1, RdWb≠0 and RdWb equals the read index, read data = ResultWb the same cycle.
- ID/EX register:
  - Latency 1 cycle; all outputs registered.
  - Bubble = all controls and data 0, PC fields = RST_PC.
- Squash state machine, states RUN and SQUASH (squash_pend):
  - RUN, FlushEx=1 at edge: load bubble, go to SQUASH. The wrong-path instruction currently in decode is killed.
  - SQUASH at edge: load bubble, go to RUN. The second wrong-path instruction, loaded by fetch on the redirect edge, is killed.
  - SQUASH with FlushEx=1: load bubble, stay SQUASH. FlushEx has priority.
  - Net effect: a taken branch costs exactly 2 bubbles.
- Writeback proceeds during bubbles; flush never blocks register writes.
- Reset mid-squash: returns to RUN immediately; outputs hold bubble values until the first edge after rst deasserts.
- No stall input: ID/EX loads every cycle.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - funct constants;
  - ALU codes ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT;
  - squash state encoding.
- One sub-module, register_file: 2 read ports and 1 write port, async active-low reset, bypass, r0 hardwired to zero.
- Control decode stays inline as combinational logic.

Test Plan:
- Reset release, InstrDe=32'h00000000 → after 1 edge: all controls 0, RD1Ex=RD2Ex=0, PCEx=0.
- Write $5=32'h1234 (RegWriteWb=1, RdWb=5). Next cycle InstrDe=add $3,$5,$5 (32'h00A51820) → RegWriteEx=1, RegDstEx=1, ALUControlEx=010, RD1Ex=RD2Ex=32'h1234, RdEx=3.
- Same-cycle bypass: RegWriteWb=1, RdWb=8, ResultWb=32'hCAFE with InstrDe=lw $9,-4($8) (32'h8D09FFFC) → RD1Ex=32'hCAFE, ImmExtEx=32'hFFFFFFFC, ResultSrcEx=1, ALUSrcEx=1.
- Write to $0: RegWriteWb=1, RdWb=0, ResultWb=32'hFFFF, then decode add $1,$0,$0 → RD1Ex=RD2Ex=0.
- FlushEx=1 for one cycle while InstrDe streams valid addi instructions → the next 2 edges give bubbles (RegWriteEx=0, PCEx=0); the third edge passes the instruction through.
- Assert rst=0 during SQUASH → outputs go to 0 asynchronously. After release, the first instruction decodes normally with no extra bubble.
